// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, start/ready/done_tick handshake.
// Optional SEQ_DIVIDER_BCD_CLAMP_EN saturates the quotient at 9999 for a 4-digit BCD stage.
module seq_divider #(
    parameter int unsigned W = 20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] dvnd,
    input  logic [W-1:0] dvsr,
    output logic         ready,
    output logic         done_tick,
    output logic [W-1:0] quo,
    output logic [W-1:0] rmd
);

    localparam int unsigned CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OP   = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t         state;
    logic [W-1:0]   rh;
    logic [W-1:0]   rl;
    logic [W-1:0]   dv;
    logic [CW-1:0]  cnt;

    logic [W:0]     trial;
    logic [W:0]     diff;
    logic           q_bit;
    logic [W-1:0]   rh_next;
    logic [W-1:0]   rl_next;
    logic [CW-1:0]  cnt_next;
    logic [W-1:0]   quo_final;

    // Trial keeps rh's MSB so a partial remainder >= 2^(W-1) is not truncated.
    always_comb begin
        trial    = {rh, rl[W-1]};
        diff     = trial - {1'b0, dv};
        q_bit    = (trial >= {1'b0, dv});
        rh_next  = q_bit ? diff[W-1:0] : trial[W-1:0];
        rl_next  = {rl[W-2:0], q_bit};
        cnt_next = cnt - CW'(1);
    end

`ifdef SEQ_DIVIDER_BCD_CLAMP_EN
    localparam int unsigned QW = (W > 14) ? W : 14;
    logic [QW-1:0] q_ext;

    always_comb begin
        q_ext     = QW'(rl_next);
        quo_final = (q_ext > QW'(9999)) ? W'(9999) : rl_next;
    end
`else
    always_comb begin
        quo_final = rl_next;
    end
`endif

    assign ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            rh        <= '0;
            rl        <= '0;
            dv        <= '0;
            cnt       <= '0;
            quo       <= '0;
            rmd       <= '0;
            done_tick <= 1'b0;
        end else begin
            done_tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dv    <= dvsr;
                        rl    <= dvnd;
                        rh    <= '0;
                        cnt   <= CW'(W);
                        state <= OP;
                    end
                end
                OP: begin
                    rh  <= rh_next;
                    rl  <= rl_next;
                    cnt <= cnt_next;
                    // Results are published on the final iteration edge so they are valid in DONE.
                    if (cnt_next == '0) begin
                        quo       <= quo_final;
                        rmd       <= rh_next;
                        done_tick <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (W=20); expectations follow SEQ_DIVIDER_BCD_CLAMP_EN.
module tb_seq_divider;

    localparam int unsigned W = 20;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] dvnd;
    logic [W-1:0] dvsr;
    logic         ready;
    logic         done_tick;
    logic [W-1:0] quo;
    logic [W-1:0] rmd;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] bv_a [70];
    logic [W-1:0] bv_b [70];

    seq_divider #(.W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dvnd      (dvnd),
        .dvsr      (dvsr),
        .ready     (ready),
        .done_tick (done_tick),
        .quo       (quo),
        .rmd       (rmd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] clampq(input logic [W-1:0] q);
`ifdef SEQ_DIVIDER_BCD_CLAMP_EN
        return (q > W'(9999)) ? W'(9999) : q;
`else
        return q;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issues one start pulse and checks latency, ready, the one-cycle done pulse and results.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eq, input logic [W-1:0] er, input string tag);
        int n;
        int bad_ready;
        @(negedge clk);
        dvnd  = a;
        dvsr  = b;
        start = 1'b1;
        check({tag, " ready_idle"}, 32'(ready), 32'd1);
        @(negedge clk);
        start     = 1'b0;
        dvnd      = W'($urandom);
        dvsr      = W'($urandom);
        n         = 1;
        bad_ready = 0;
        while (!done_tick && n < 100) begin
            if (ready) bad_ready++;
            @(negedge clk);
            n++;
        end
        if (ready) bad_ready++;
        check({tag, " latency"}, 32'(n), 32'(W + 1));
        check({tag, " ready_low"}, 32'(bad_ready), 32'd0);
        check({tag, " quo"}, 32'(quo), 32'(eq));
        check({tag, " rmd"}, 32'(rmd), 32'(er));
        @(negedge clk);
        check({tag, " done_one_cycle"}, 32'(done_tick), 32'd0);
        check({tag, " ready_back"}, 32'(ready), 32'd1);
        check({tag, " quo_hold"}, 32'(quo), 32'(eq));
    endtask

    initial begin
        int k;
        int pulses;
        reset = 1'b0;
        start = 1'b0;
        dvnd  = '0;
        dvsr  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        check("rst ready", 32'(ready), 32'd1);
        check("rst done", 32'(done_tick), 32'd0);
        check("rst quo", 32'(quo), 32'd0);
        check("rst rmd", 32'(rmd), 32'd0);

        run_div(20'd1000000, 20'd1000, clampq(20'd1000), 20'd0, "basic");
        run_div(20'd1000000, 20'd7, clampq(20'd142857), 20'd1, "rem7");
        run_div(20'd1000000, 20'd100, clampq(20'd10000), 20'd0, "clamp100");
        run_div(20'd12345, 20'd0, clampq(20'hFFFFF), 20'd12345, "div0");
        run_div(20'hFFFFF, 20'h80000, 20'd1, 20'h7FFFF, "bigdiv");
        run_div(20'hFFFFF, 20'hFFFFF, 20'd1, 20'd0, "equal");
        run_div(20'd5, 20'd9, 20'd0, 20'd5, "small");
        run_div(20'hFFFFF, 20'd1, clampq(20'hFFFFF), 20'd0, "div1");

        // start held for 50 cycles; accepts land at cycles 0, 22, 44.
        for (int i = 0; i < 70; i++) begin
            bv_a[i] = W'(1000000 - i * 9973);
            bv_b[i] = W'(7 + i * 13);
        end
        pulses = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (i >= 21) begin
                check($sformatf("busy done c%0d", i), 32'(done_tick),
                      32'((i == 21) || (i == 43) || (i == 65)));
                if (i == 21 || i == 43 || i == 65) begin
                    k = i - 21;
                    pulses++;
                    check($sformatf("busy quo c%0d", i), 32'(quo), 32'(clampq(bv_a[k] / bv_b[k])));
                    check($sformatf("busy rmd c%0d", i), 32'(rmd), 32'(bv_a[k] % bv_b[k]));
                end
            end
            start = (i < 50);
            dvnd  = bv_a[i];
            dvsr  = bv_b[i];
        end
        check("busy pulses", 32'(pulses), 32'd3);
        start = 1'b0;
        repeat (30) @(negedge clk);

        // Reset during op cycle 10 must abort with no done_tick.
        @(negedge clk);
        dvnd  = 20'd1000000;
        dvsr  = 20'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("abort ready", 32'(ready), 32'd1);
        check("abort quo", 32'(quo), 32'd0);
        check("abort rmd", 32'(rmd), 32'd0);
        check("abort done", 32'(done_tick), 32'd0);
        pulses = 0;
        repeat (30) begin
            @(negedge clk);
            if (done_tick) pulses++;
        end
        check("abort no_done", 32'(pulses), 32'd0);
        run_div(20'd1000000, 20'd1000, clampq(20'd1000), 20'd0, "after_abort");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
